// File: rtl/delay_ram_scheduler.sv
// Time-multiplexes one single-port delay-line RAM per audio frame: write the new
// sample, then read a modulated tap and a fixed tap, then present both taps.
module delay_ram_scheduler #(
    parameter int ADDR_W      = 16,
    parameter int MOD_DEPTH   = 240,
    parameter int SYNC_STAGES = 2,
    parameter int RAM_LATENCY = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              ADCLRCK,
    input  logic              enable,
    input  logic [15:0]       sample_in,
    input  logic [31:0]       sin,
    input  logic [ADDR_W-1:0] fixed_delay,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_d,
    output logic              mem_we,
    input  logic [15:0]       mem_q,
    output logic [15:0]       tap_mod_out,
    output logic [15:0]       tap_fix_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WRITE    = 3'd1;
    localparam logic [2:0] RD_MOD   = 3'd2;
    localparam logic [2:0] WAIT_MOD = 3'd3;
    localparam logic [2:0] RD_FIX   = 3'd4;
    localparam logic [2:0] WAIT_FIX = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [2:0]             r_state;
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_fp;
    logic [ADDR_W-1:0]      r_dmod;
    logic [ADDR_W-1:0]      r_dfix;
    logic [15:0]            r_mod;
    logic [1:0]             r_wait;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [15:0]            r_mem_d;
    logic                   r_mem_we;
    logic [15:0]            r_tap_mod;
    logic [15:0]            r_tap_fix;
    logic                   r_valid;
    logic                   r_overrun;

    logic                   w_sync_lrck;
    logic                   w_frame_edge;
    logic [47:0]            w_prod;
    logic [47:0]            w_shift;
    logic [ADDR_W-1:0]      w_dmod_sat;
    logic                   w_wait_last;

    assign w_sync_lrck  = r_sync[SYNC_STAGES-1];
    assign w_frame_edge = w_sync_lrck & ~r_prev;

    // Full-width product so a large LFO value saturates instead of wrapping.
    assign w_prod      = 48'(MOD_DEPTH) * {16'd0, sin};
    assign w_shift     = w_prod >> 9;
    assign w_dmod_sat  = (|w_shift[47:ADDR_W]) ? {ADDR_W{1'b1}} : w_shift[ADDR_W-1:0];
    assign w_wait_last = (r_wait == 2'(RAM_LATENCY - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync     <= '0;
            r_prev     <= 1'b0;
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_fp       <= '0;
            r_dmod     <= '0;
            r_dfix     <= '0;
            r_mod      <= '0;
            r_wait     <= '0;
            r_mem_addr <= '0;
            r_mem_d    <= '0;
            r_mem_we   <= 1'b0;
            r_tap_mod  <= '0;
            r_tap_fix  <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], ADCLRCK};
            r_prev  <= w_sync_lrck;
            r_valid <= 1'b0;
            if (w_frame_edge && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            // Memory port registers are loaded one state early so they are stable
            // for the whole cycle of the state that owns them.
            case (r_state)
                IDLE: begin
                    if (w_frame_edge && enable) begin
                        r_fp       <= r_wr_ptr;
                        r_dmod     <= w_dmod_sat;
                        r_dfix     <= fixed_delay;
                        r_mem_addr <= r_wr_ptr;
                        r_mem_d    <= sample_in;
                        r_mem_we   <= 1'b1;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    r_wr_ptr   <= r_fp + 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_fp - r_dmod;
                    r_state    <= RD_MOD;
                end
                RD_MOD: begin
                    r_wait  <= '0;
                    r_state <= WAIT_MOD;
                end
                WAIT_MOD: begin
                    if (w_wait_last) begin
                        r_mod      <= mem_q;
                        r_mem_addr <= r_fp - r_dfix;
                        r_state    <= RD_FIX;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                RD_FIX: begin
                    r_wait  <= '0;
                    r_state <= WAIT_FIX;
                end
                WAIT_FIX: begin
                    if (w_wait_last) begin
                        r_tap_mod <= r_mod;
                        r_tap_fix <= mem_q;
                        r_valid   <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_d        = r_mem_d;
    assign mem_we       = r_mem_we;
    assign tap_mod_out  = r_tap_mod;
    assign tap_fix_out  = r_tap_fix;
    assign sample_valid = r_valid;
    assign busy         = (r_state != IDLE);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_delay_ram_scheduler.sv
// Randomized bench for delay_ram_scheduler: a frame-level delay-line model
// predicts RAM addresses, write data and tap values for every frame.
module tb_delay_ram_scheduler;

    localparam int RL = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        adcLrck;
    logic        enable;
    logic [15:0] sampleIn;
    logic [31:0] sinValue;
    logic [15:0] fixedDelay;
    logic [15:0] memAddr;
    logic [15:0] memD;
    logic        memWe;
    logic [15:0] memQ;
    logic [15:0] tapModOut;
    logic [15:0] tapFixOut;
    logic        sampleValid;
    logic        busy;
    logic        overrun;

    int checkCount = 0;
    int errorCount = 0;
    int weCount    = 0;
    int validCount = 0;

    logic [15:0] refRam [65536];
    logic [15:0] refWp;
    logic        refOverrun;
    logic [15:0] lastModAddr;

    logic [15:0] ram [65536];
    logic [15:0] rdQ;
    bit          ramReady = 1'b0;

    delay_ram_scheduler #(
        .ADDR_W(16),
        .MOD_DEPTH(240),
        .SYNC_STAGES(2),
        .RAM_LATENCY(RL)
    ) dut (
        .CLOCK_50(clock),
        .reset(reset),
        .ADCLRCK(adcLrck),
        .enable(enable),
        .sample_in(sampleIn),
        .sin(sinValue),
        .fixed_delay(fixedDelay),
        .mem_addr(memAddr),
        .mem_d(memD),
        .mem_we(memWe),
        .mem_q(memQ),
        .tap_mod_out(tapModOut),
        .tap_fix_out(tapFixOut),
        .sample_valid(sampleValid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] initVal(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction

    // Synchronous-read RAM with one cycle of latency, preloaded with a known pattern.
    always @(posedge clock) begin
        if (!ramReady) begin
            for (int i = 0; i < 65536; i++) ram[i] = initVal(16'(i));
            ramReady = 1'b1;
        end
        rdQ <= ram[memAddr];
        if (memWe) ram[memAddr] = memD;
    end
    assign memQ = rdQ;

    always @(negedge clock) begin
        if (memWe) weCount++;
        if (sampleValid) validCount++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic [31:0] sn,
                                 input logic [15:0] fd, input logic en);
        sampleIn   = s;
        sinValue   = sn;
        fixedDelay = fd;
        enable     = en;
    endtask

    function automatic logic [15:0] dmodOf(input logic [31:0] sn);
        longint unsigned p;
        p = ({32'd0, sn} * 64'd240) >> 9;
        return (p > 64'd65535) ? 16'hFFFF : 16'(p);
    endfunction

    // Waits a bounded number of cycles for the write strobe; returns 1 if seen.
    task automatic waitForWrite(output bit seen);
        int n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clock);
            n++;
            if (memWe === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("writeTimeout", 32'd0, 32'd1);
    endtask

    // One complete frame; the model predicts the write and both taps up front.
    task automatic runFrame(input logic [15:0] s, input logic [31:0] sn, input logic [15:0] fd,
                            input bit scramble, input bit injectEdge);
        logic [15:0] wp, dmod, modAddr, fixAddr, expMod, expFix;
        bit seen;
        wp      = refWp;
        dmod    = dmodOf(sn);
        modAddr = wp - dmod;
        fixAddr = wp - fd;
        refRam[wp] = s;
        expMod  = refRam[modAddr];
        expFix  = refRam[fixAddr];
        refWp   = wp + 16'd1;

        applyStimulus(s, sn, fd, 1'b1);
        @(negedge clock);
        adcLrck = 1'b1;
        waitForWrite(seen);
        if (!seen) begin
            adcLrck = 1'b0;
            return;
        end
        checkOutput("writeAddr", memAddr, wp);
        checkOutput("writeData", memD, s);
        checkOutput("busyInFrame", busy, 1'b1);
        adcLrck = 1'b0;
        if (scramble) applyStimulus(16'($urandom), $urandom, 16'($urandom), 1'($urandom));
        @(negedge clock);
        lastModAddr = memAddr;
        checkOutput("modAddr", memAddr, modAddr);
        checkOutput("readWe", memWe, 1'b0);
        if (injectEdge) adcLrck = 1'b1;
        repeat (RL + 1) @(negedge clock);
        checkOutput("fixAddr", memAddr, fixAddr);
        repeat (RL + 1) @(negedge clock);
        checkOutput("validPulse", sampleValid, 1'b1);
        checkOutput("tapMod", tapModOut, expMod);
        checkOutput("tapFix", tapFixOut, expFix);
        @(negedge clock);
        checkOutput("validEnd", sampleValid, 1'b0);
        checkOutput("idleAfter", busy, 1'b0);
        if (injectEdge) refOverrun = 1'b1;
        checkOutput("overrunFlag", overrun, refOverrun);
        adcLrck = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int weBase, validBase;
        logic [15:0] fpSat;
        bit seen;

        for (int i = 0; i < 65536; i++) refRam[i] = initVal(16'(i));
        refWp      = 16'd0;
        refOverrun = 1'b0;
        reset      = 1'b1;
        adcLrck    = 1'b0;
        applyStimulus(16'd0, 32'd0, 16'd0, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("rstAddr", memAddr, 16'd0);
        checkOutput("rstData", memD, 16'd0);
        checkOutput("rstWe", memWe, 1'b0);
        checkOutput("rstTapMod", tapModOut, 16'd0);
        checkOutput("rstTapFix", tapFixOut, 16'd0);
        checkOutput("rstValid", sampleValid, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstOverrun", overrun, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] directed frames 100/200/300");
        runFrame(16'd100, 32'd0, 16'd1, 1'b0, 1'b0);
        runFrame(16'd200, 32'd0, 16'd1, 1'b0, 1'b0);
        runFrame(16'd300, 32'd0, 16'd1, 1'b0, 1'b0);
        runFrame(16'h1234, 32'd0, 16'd0, 1'b0, 1'b0);
        runFrame(16'hBEEF, 32'd77, 16'd3, 1'b0, 1'b0);

        $display("[TB] wrap and saturation");
        runFrame(16'h0AAA, 32'd512, 16'd2, 1'b0, 1'b0);
        checkOutput("wrapAddrFF15", lastModAddr, 16'hFF15);
        fpSat = refWp;
        runFrame(16'h0BBB, 32'hFFFF_FFFF, 16'd4, 1'b0, 1'b0);
        checkOutput("satAddr", lastModAddr, fpSat + 16'd1);

        $display("[TB] overrun");
        weBase    = weCount;
        validBase = validCount;
        runFrame(16'h0CCC, 32'd300, 16'd5, 1'b0, 1'b1);
        repeat (6) @(negedge clock);
        checkOutput("overrunValidCount", validCount - validBase, 1);
        checkOutput("overrunWeCount", weCount - weBase, 1);
        runFrame(16'h0DDD, 32'd100, 16'd1, 1'b0, 1'b0);

        $display("[TB] reset during WAIT_MOD");
        applyStimulus(16'h0EEE, 32'd10, 16'd2, 1'b1);
        @(negedge clock);
        adcLrck = 1'b1;
        waitForWrite(seen);
        if (seen) begin
            refRam[refWp] = 16'h0EEE;
            adcLrck = 1'b0;
            repeat (RL + 1) @(negedge clock);
            checkOutput("busyBeforeReset", busy, 1'b1);
            reset = 1'b1;
            @(negedge clock);
            checkOutput("midRstBusy", busy, 1'b0);
            checkOutput("midRstWe", memWe, 1'b0);
            checkOutput("midRstTapMod", tapModOut, 16'd0);
            checkOutput("midRstTapFix", tapFixOut, 16'd0);
            checkOutput("midRstOverrun", overrun, 1'b0);
        end
        adcLrck    = 1'b0;
        reset      = 1'b0;
        refWp      = 16'd0;
        refOverrun = 1'b0;
        repeat (3) @(negedge clock);
        runFrame(16'h0F0F, 32'd200, 16'd1, 1'b0, 1'b0);

        $display("[TB] enable low");
        weBase    = weCount;
        validBase = validCount;
        applyStimulus(16'h7777, 32'd50, 16'd1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            adcLrck = 1'b1;
            repeat (5) @(negedge clock);
            adcLrck = 1'b0;
            repeat (5) @(negedge clock);
        end
        checkOutput("disabledWe", weCount - weBase, 0);
        checkOutput("disabledValid", validCount - validBase, 0);
        checkOutput("disabledBusy", busy, 1'b0);
        runFrame(16'h1111, 32'd20, 16'd2, 1'b0, 1'b0);

        $display("[TB] randomized frames");
        for (int k = 0; k < 30; k++) begin
            logic [31:0] sn;
            logic [15:0] fd;
            sn = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
            fd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
            runFrame(16'($urandom), sn, fd, 1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/delay_ram_scheduler.md
Name: delay_ram_scheduler

Overview:
- Sequences one shared single-port delay-line RAM for the vibrato path. It runs on the system clock instead of clocking the datapath directly on ADCLRCK.
- Once per audio frame (ADCLRCK rising edge), it performs three RAM accesses:
  - writes the new left sample into a circular buffer;
  - reads a modulated tap, with delay derived from `sin`;
  - reads a fixed tap, with delay set by a port.
- It presents both taps, plus a one-cycle valid strobe, to the downstream mixer and codec.

Parameters:
- ADDR_W, 16, RAM address width; the buffer depth is 2^ADDR_W samples.
- MOD_DEPTH, 240, multiplier for the modulated delay: dmod = (MOD_DEPTH*sin)>>9.
- SYNC_STAGES, 2, number of flip-flops synchronising ADCLRCK into CLOCK_50 (minimum 2).
- RAM_LATENCY, 1, cycles from the address being presented to mem_q being valid (1 or 2).

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ADCLRCK  in  1  codec frame clock; asynchronous to CLOCK_50.
- enable  in  1  when 0, new frames are not started.
- sample_in  in  16  signed left input sample.
- sin  in  32  unsigned LFO value (0..511 nominal).
- fixed_delay  in  ADDR_W  fixed-tap delay, in samples.
- mem_addr  out  ADDR_W  RAM address.
- mem_d  out  16  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  16  RAM read data.
- tap_mod_out  out  16  signed modulated-tap sample.
- tap_fix_out  out  16  signed fixed-tap sample.
- sample_valid  out  1  one-cycle pulse when both taps update.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky flag: a frame edge arrived while busy.

Behaviour:
- Reset values:
  - All outputs are 0, including mem_addr, mem_d, mem_we, both taps, sample_valid, busy and overrun.
  - wr_ptr = 0, the synchroniser is cleared, prev_lrck = 0, and state = IDLE.
- Reset mid-frame: on the next clock edge, return to IDLE, drive mem_we = 0, discard any partial tap data, and zero the taps.
- Edge detect: frame_edge = sync_lrck & ~prev_lrck. It is seen SYNC_STAGES+1 cycles after ADCLRCK rises.
- IDLE, on frame_edge & enable:
  - Latch s = sample_in and fp = wr_ptr.
  - Latch dmod = (MOD_DEPTH*sin)>>9. Compute it in 48 bits, then saturate to 2^ADDR_W-1.
  - Latch dfix = fixed_delay.
  - Go to WRITE.
- IDLE, on frame_edge with enable = 0: the edge is ignored; outputs hold and overrun is unaffected.
- WRITE (1 cycle):
  - Drive mem_addr = fp, mem_d = s, mem_we = 1.
  - Set wr_ptr = fp+1, wrapping modulo 2^ADDR_W.
  - Go to RD_MOD.
- RD_MOD (1 cycle): drive mem_addr = (fp - dmod) mod 2^ADDR_W with mem_we = 0, then go to WAIT_MOD.
- WAIT_MOD (RAM_LATENCY cycles): on its last cycle, capture mem_q into an internal mod_reg, then go to RD_FIX.
- RD_FIX / WAIT_FIX: same as RD_MOD / WAIT_MOD, but with address (fp - dfix) mod 2^ADDR_W, capturing into fix_reg.
- DONE (1 cycle):
  - Set tap_mod_out = mod_reg and tap_fix_out = fix_reg in the same cycle.
  - Pulse sample_valid = 1.
  - Go to IDLE.
- Latency: from the frame_edge cycle E, WRITE is at E+1 and sample_valid is at E+4+2*RAM_LATENCY.
- Delay-0 boundary: a read at delay 0 returns the sample written in this same frame, because the write always precedes the reads.
- Pointer wrap: reads at a delay greater than fp wrap to the top of the buffer; no special-casing is done.
- Overrun: frame_edge while state != IDLE sets overrun to 1 (cleared only by reset). That frame is dropped and the current sequence completes unchanged.
- Between frames: mem_we is high only in WRITE. mem_addr and mem_d hold their last values in IDLE.
- Mid-frame input changes: changes to enable, sin or fixed_delay during a frame do not affect it, because all are latched at the frame start.

Test Plan:
- Reset, then 3 frames with sample_in = 100, 200, 300, sin = 0, fixed_delay = 1:
  - mem_we pulses at addresses 0, 1, 2.
  - tap_mod_out = 100, 200, 300.
  - tap_fix_out = (initial RAM content), 100, 200.
- sin = 512, MOD_DEPTH = 240, fp = 5 gives dmod = 240, so the modulated-read mem_addr = 0xFF15 (wrap).
- sin = 0xFFFFFFFF gives dmod saturated to 0xFFFF, so the read address = fp+1.
- Toggle ADCLRCK twice within 4+2*RAM_LATENCY cycles of the first detected edge:
  - overrun = 1 and stays high.
  - Exactly one sample_valid pulse occurs.
  - wr_ptr advances by 1.
- Assert reset during WAIT_MOD:
  - Next cycle: busy = 0, mem_we = 0, taps = 0, overrun = 0.
  - The following frame writes at address 0.
- enable = 0 with 5 edges: no mem_we, no sample_valid, and wr_ptr is unchanged. Re-enabling resumes at the held wr_ptr.
